// File: rtl/rot_pixel_fetch_if.sv
// Pixel-stream, frame-store and status signals of rot_pixel_fetch.
// ROT_TEST_PATTERN_EN adds the i_test select line.
interface rot_pixel_fetch_if;
  logic        i_frame_start;
  logic        i_valid;
  logic [9:0]  i_x;
  logic [9:0]  i_y;
  logic        i_rot_req;
  logic [1:0]  i_angle;
  logic        o_mem_rd;
  logic [15:0] o_mem_addr;
  logic [23:0] i_mem_rdata;
  logic        o_valid;
  logic [23:0] o_rgb;
  logic        o_pending;
  logic [1:0]  o_angle;
  logic [7:0]  o_frame_cnt;
`ifdef ROT_TEST_PATTERN_EN
  logic        i_test;
`endif

  // Master is the timing generator plus SRAM side; slave is the fetch stage.
  modport master (
`ifdef ROT_TEST_PATTERN_EN
    output i_test,
`endif
    output i_frame_start, i_valid, i_x, i_y, i_rot_req, i_angle, i_mem_rdata,
    input  o_mem_rd, o_mem_addr, o_valid, o_rgb, o_pending, o_angle, o_frame_cnt
  );

  modport slave (
`ifdef ROT_TEST_PATTERN_EN
    input  i_test,
`endif
    input  i_frame_start, i_valid, i_x, i_y, i_rot_req, i_angle, i_mem_rdata,
    output o_mem_rd, o_mem_addr, o_valid, o_rgb, o_pending, o_angle, o_frame_cnt
  );
endinterface

// File: rtl/rot_pixel_fetch.sv
// Maps visible pixels into a rotated 256x256 window and fetches RGB from the frame store.
// Optional macro ROT_TEST_PATTERN_EN replaces in-window SRAM data with a coordinate pattern.
module rot_pixel_fetch #(
  parameter int          MEM_LAT    = 2,
  parameter int          WIN_X0     = 192,
  parameter int          WIN_Y0     = 112,
  parameter logic [23:0] BORDER_RGB = 24'h202020
) (
  input logic i_clk,
  input logic i_rst,
  rot_pixel_fetch_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [1:0]  pend_angle;
  logic [1:0]  eff_angle;
  logic        run_now;
  logic        in_win;
  logic        rd_now;
  logic [9:0]  x_off;
  logic [9:0]  y_off;
  logic [7:0]  u;
  logic [7:0]  v;
  logic [7:0]  row;
  logic [7:0]  col;
  logic [MEM_LAT:0] v_pipe;
  logic [MEM_LAT:0] w_pipe;

`ifdef ROT_TEST_PATTERN_EN
  logic [MEM_LAT:0] t_pipe;
  logic [15:0]      t_data [MEM_LAT+1];
`endif

  // A pixel in the frame-start cycle already sees the angle being applied.
  always_comb begin
    eff_angle = bus.o_angle;
    if (bus.i_frame_start) begin
      if (bus.i_rot_req)
        eff_angle = bus.i_angle;
      else if (bus.o_pending)
        eff_angle = pend_angle;
    end
  end

  assign run_now = (state == RUN) || bus.i_frame_start;

  always_comb begin
    x_off  = bus.i_x - 10'(WIN_X0);
    y_off  = bus.i_y - 10'(WIN_Y0);
    in_win = (bus.i_x >= 10'(WIN_X0)) && (x_off < 10'd256) &&
             (bus.i_y >= 10'(WIN_Y0)) && (y_off < 10'd256);
    u = x_off[7:0];
    v = y_off[7:0];
    row = v;
    col = u;
    case (eff_angle)
      2'd0: begin row = v;         col = u;         end
      2'd1: begin row = 8'd255 - u; col = v;         end
      2'd2: begin row = 8'd255 - v; col = 8'd255 - u; end
      default: begin row = u;      col = 8'd255 - v; end
    endcase
  end

`ifdef ROT_TEST_PATTERN_EN
  assign rd_now = bus.i_valid && in_win && run_now && !bus.i_test;
`else
  assign rd_now = bus.i_valid && in_win && run_now;
`endif

  // Frame sequencing: run state, angle pending/apply and frame counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state           <= IDLE;
      pend_angle      <= 2'd0;
      bus.o_pending   <= 1'b0;
      bus.o_angle     <= 2'd0;
      bus.o_frame_cnt <= 8'd0;
    end else begin
      if (bus.i_frame_start) begin
        state           <= RUN;
        bus.o_frame_cnt <= bus.o_frame_cnt + 8'd1;
        bus.o_angle     <= eff_angle;
        bus.o_pending   <= 1'b0;
        if (bus.i_rot_req)
          pend_angle <= bus.i_angle;
      end else if (bus.i_rot_req) begin
        pend_angle    <= bus.i_angle;
        bus.o_pending <= 1'b1;
      end
    end
  end

  // Read issue plus flag pipeline aligned with SRAM data return.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bus.o_mem_rd   <= 1'b0;
      bus.o_mem_addr <= 16'd0;
      v_pipe         <= '0;
      w_pipe         <= '0;
    end else begin
      bus.o_mem_rd <= rd_now;
      if (rd_now)
        bus.o_mem_addr <= {row, col};
      v_pipe <= {v_pipe[MEM_LAT-1:0], bus.i_valid && run_now};
      w_pipe <= {w_pipe[MEM_LAT-1:0], bus.i_valid && in_win && run_now};
    end
  end

`ifdef ROT_TEST_PATTERN_EN
  // Test-pattern select and coordinates ride alongside the read.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      t_pipe <= '0;
      for (int i = 0; i <= MEM_LAT; i++)
        t_data[i] <= 16'd0;
    end else begin
      t_pipe    <= {t_pipe[MEM_LAT-1:0], bus.i_test};
      t_data[0] <= {col, row};
      for (int i = 1; i <= MEM_LAT; i++)
        t_data[i] <= t_data[i-1];
    end
  end
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bus.o_valid <= 1'b0;
      bus.o_rgb   <= 24'd0;
    end else begin
      bus.o_valid <= v_pipe[MEM_LAT];
      if (w_pipe[MEM_LAT]) begin
`ifdef ROT_TEST_PATTERN_EN
        bus.o_rgb <= t_pipe[MEM_LAT] ? {t_data[MEM_LAT], 8'h80} : bus.i_mem_rdata;
`else
        bus.o_rgb <= bus.i_mem_rdata;
`endif
      end else if (v_pipe[MEM_LAT]) begin
        bus.o_rgb <= BORDER_RGB;
      end else begin
        bus.o_rgb <= 24'd0;
      end
    end
  end

endmodule

// File: tb/tb_rot_pixel_fetch.sv
// Scoreboard bench for rot_pixel_fetch: directed pixels, SRAM model, decoupled monitor.
module tb_rot_pixel_fetch;
  localparam int MEM_LAT = 2;

  typedef struct {
    logic [23:0] rgb;
    int          due;
  } exp_t;

  logic i_clk;
  logic i_rst;
  rot_pixel_fetch_if bus();

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_frames = 0;
  exp_t        exp_q[$];
  logic [15:0] addr_q[$];

  logic [MEM_LAT-1:0] rd_dly;
  logic [15:0]        addr_dly [MEM_LAT];

  rot_pixel_fetch #(.MEM_LAT(MEM_LAT)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus(bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Frame-store SRAM with a fixed read latency.
  function automatic logic [23:0] memData(input logic [15:0] a);
    return (a == 16'h0000) ? 24'hABCDEF : {8'hC3, a};
  endfunction

  always @(posedge i_clk) begin
    rd_dly[0]   <= bus.o_mem_rd;
    addr_dly[0] <= bus.o_mem_addr;
    for (int i = 1; i < MEM_LAT; i++) begin
      rd_dly[i]   <= rd_dly[i-1];
      addr_dly[i] <= addr_dly[i-1];
    end
  end

  always_comb begin
    bus.i_mem_rdata = 24'd0;
    if (rd_dly[MEM_LAT-1])
      bus.i_mem_rdata = memData(addr_dly[MEM_LAT-1]);
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic reportFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got unexpected output, expected none (cycle %0d)", name, cyc);
  endtask

  // Drive one cycle of inputs and queue what the DUT must produce.
  task automatic applyStimulus(input logic fs, input logic rot, input logic [1:0] ang,
                               input logic vld, input logic [9:0] x, input logic [9:0] y,
                               input logic exp_rd, input logic [15:0] exp_addr,
                               input logic exp_out, input logic [23:0] exp_rgb);
    exp_t e;
    bus.i_frame_start = fs;
    bus.i_rot_req     = rot;
    bus.i_angle       = ang;
    bus.i_valid       = vld;
    bus.i_x           = x;
    bus.i_y           = y;
    if (fs) exp_frames++;
    if (exp_rd) addr_q.push_back(exp_addr);
    if (exp_out) begin
      e.rgb = exp_rgb;
      e.due = cyc + MEM_LAT + 2;
      exp_q.push_back(e);
    end
    @(posedge i_clk);
    #1;
    bus.i_frame_start = 1'b0;
    bus.i_rot_req     = 1'b0;
    bus.i_valid       = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_mem_rd"},    32'(bus.o_mem_rd), 32'd0);
    checkOutput({tag, "_mem_addr"},  32'(bus.o_mem_addr), 32'd0);
    checkOutput({tag, "_valid"},     32'(bus.o_valid), 32'd0);
    checkOutput({tag, "_rgb"},       32'(bus.o_rgb), 32'd0);
    checkOutput({tag, "_pending"},   32'(bus.o_pending), 32'd0);
    checkOutput({tag, "_angle"},     32'(bus.o_angle), 32'd0);
    checkOutput({tag, "_frame_cnt"}, 32'(bus.o_frame_cnt), 32'd0);
  endtask

  // Monitor: pops expectations whenever the DUT presents a read or a pixel.
  always @(negedge i_clk) begin
    exp_t e;
    if (bus.o_mem_rd) begin
      if (addr_q.size() == 0) reportFail("mem_rd_unexpected");
      else checkOutput("mem_addr", 32'(bus.o_mem_addr), 32'(addr_q.pop_front()));
    end
    if (bus.o_valid) begin
      if (exp_q.size() == 0) begin
        reportFail("valid_unexpected");
      end else begin
        e = exp_q.pop_front();
        checkOutput("rgb", 32'(bus.o_rgb), 32'(e.rgb));
        checkOutput("latency", 32'(cyc), 32'(e.due));
      end
    end else begin
      checkOutput("rgb_when_invalid", 32'(bus.o_rgb), 32'd0);
    end
  end

  initial begin
    i_rst = 1'b1;
    bus.i_frame_start = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_x = 10'd0;
    bus.i_y = 10'd0;
    bus.i_rot_req = 1'b0;
    bus.i_angle = 2'd0;
`ifdef ROT_TEST_PATTERN_EN
    bus.i_test = 1'b0;
`endif
    idle(3);
    checkAllZero("reset");
    i_rst = 1'b0;

    // IDLE: valid pixels without a frame start produce nothing.
    applyStimulus(0, 0, 0, 1, 10'd192, 10'd112, 0, 16'h0, 0, 24'h0);
    applyStimulus(0, 0, 0, 1, 10'd200, 10'd120, 0, 16'h0, 0, 24'h0);
    idle(6);
    checkOutput("idle_valid", 32'(bus.o_valid), 32'd0);
    checkOutput("idle_frame_cnt", 32'(bus.o_frame_cnt), 32'd0);

    // Angle 0.
    applyStimulus(1, 0, 0, 1, 10'd192, 10'd112, 1, 16'h0000, 1, 24'hABCDEF);
    applyStimulus(0, 0, 0, 1, 10'd200, 10'd120, 1, 16'h0808, 1, 24'hC30808);
    applyStimulus(0, 0, 0, 1, 10'd100, 10'd200, 0, 16'h0, 1, 24'h202020);
    applyStimulus(0, 0, 0, 0, 10'd192, 10'd112, 0, 16'h0, 0, 24'h0);
    checkOutput("frame_cnt_1", 32'(bus.o_frame_cnt), 32'd1);
    idle(6);

    // Angle 1 via a pending request.
    applyStimulus(0, 1, 1, 0, 10'd0, 10'd0, 0, 16'h0, 0, 24'h0);
    checkOutput("pending_set", 32'(bus.o_pending), 32'd1);
    checkOutput("angle_before_fs", 32'(bus.o_angle), 32'd0);
    applyStimulus(1, 0, 0, 1, 10'd192, 10'd112, 1, 16'hFF00, 1, 24'hC3FF00);
    checkOutput("angle_1", 32'(bus.o_angle), 32'd1);
    checkOutput("pending_clear_1", 32'(bus.o_pending), 32'd0);
    applyStimulus(0, 0, 0, 1, 10'd193, 10'd112, 1, 16'hFE00, 1, 24'hC3FE00);
    idle(6);

    // Overwritten request: 3 then 2, so angle 2 applies; window edges.
    applyStimulus(0, 1, 3, 0, 10'd0, 10'd0, 0, 16'h0, 0, 24'h0);
    applyStimulus(0, 1, 2, 0, 10'd0, 10'd0, 0, 16'h0, 0, 24'h0);
    applyStimulus(1, 0, 0, 1, 10'd193, 10'd112, 1, 16'hFFFE, 1, 24'hC3FFFE);
    checkOutput("angle_2", 32'(bus.o_angle), 32'd2);
    applyStimulus(0, 0, 0, 1, 10'd447, 10'd367, 1, 16'h0000, 1, 24'hABCDEF);
    applyStimulus(0, 0, 0, 1, 10'd448, 10'd112, 0, 16'h0, 1, 24'h202020);
    applyStimulus(0, 0, 0, 1, 10'd191, 10'd200, 0, 16'h0, 1, 24'h202020);
    applyStimulus(0, 0, 0, 0, 10'd200, 10'd200, 0, 16'h0, 0, 24'h0);
    applyStimulus(0, 0, 0, 1, 10'd300, 10'd368, 0, 16'h0, 1, 24'h202020);
    applyStimulus(0, 0, 0, 1, 10'd700, 10'd200, 0, 16'h0, 1, 24'h202020);
    idle(6);

    // Request and frame start together: angle 3 applies at once.
    applyStimulus(1, 1, 3, 1, 10'd192, 10'd112, 1, 16'h00FF, 1, 24'hC300FF);
    checkOutput("angle_3", 32'(bus.o_angle), 32'd3);
    checkOutput("pending_same_cycle", 32'(bus.o_pending), 32'd0);
    applyStimulus(0, 0, 0, 1, 10'd194, 10'd113, 1, 16'h02FE, 1, 24'hC302FE);
    idle(6);

    // Frame counter wrap after 256 frame starts since reset.
    while ((exp_frames % 256) != 0)
      applyStimulus(1, 0, 0, 0, 10'd0, 10'd0, 0, 16'h0, 0, 24'h0);
    checkOutput("frame_cnt_wrap", 32'(bus.o_frame_cnt), 32'd0);
    checkOutput("angle_kept", 32'(bus.o_angle), 32'd3);

    // Reset with three reads in flight: reads happen, pixels never appear.
    applyStimulus(0, 0, 0, 1, 10'd192, 10'd112, 1, 16'h00FF, 0, 24'h0);
    applyStimulus(0, 0, 0, 1, 10'd192, 10'd112, 1, 16'h00FF, 0, 24'h0);
    applyStimulus(0, 0, 0, 1, 10'd192, 10'd112, 1, 16'h00FF, 0, 24'h0);
    @(negedge i_clk);
    #1;
    i_rst = 1'b1;
    exp_frames = 0;
    #1;
    checkAllZero("midreset");
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    applyStimulus(0, 0, 0, 1, 10'd192, 10'd112, 0, 16'h0, 0, 24'h0);
    applyStimulus(0, 0, 0, 1, 10'd200, 10'd112, 0, 16'h0, 0, 24'h0);
    idle(6);
    applyStimulus(1, 0, 0, 1, 10'd192, 10'd112, 1, 16'h0000, 1, 24'hABCDEF);
    checkOutput("post_reset_angle", 32'(bus.o_angle), 32'd0);
    checkOutput("post_reset_frame_cnt", 32'(bus.o_frame_cnt), 32'd1);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 20 && (exp_q.size() != 0 || addr_q.size() != 0); i++)
      idle(1);
    idle(2);
    checkOutput("sb_pixels_left", 32'(exp_q.size()), 32'd0);
    checkOutput("sb_reads_left", 32'(addr_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
